// File: rtl/serv_wb_wdt.sv
// serv_wb_wdt
// Watchdog counter for the Wishbone arbiter. It counts the cycles a granted
// transfer spends waiting for the slave, and flags expiry on the cycle where
// the count reaches TIMEOUT-1. TIMEOUT=0 disables expiry entirely.
//
// Ports:
//   i_clk     clock
//   i_rst     synchronous active-high reset
//   i_clr     clear the count (held while the arbiter is idle)
//   i_en      count this cycle (granted, owner requesting, no ack)
//   o_expire  high on the enabled cycle where the count equals TIMEOUT-1
module serv_wb_wdt #(
    parameter int TIMEOUT = 255,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    // A disabled watchdog still needs a legal one-bit counter.
    localparam int CW = (TW < 1) ? 1 : TW;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = (TIMEOUT > 0) && i_en && (cnt_q == LIMIT);

endmodule

// File: rtl/serv_wb_rr_arbiter.sv
// serv_wb_rr_arbiter
// Registered round-robin arbiter sharing one CPU Wishbone port between the
// SERV instruction bus (ibus) and data bus (dbus). A grant is issued one cycle
// after a request, held until the owner is acked (or aborts), and followed by
// one idle cycle. Ties go to the master that was not served last. A watchdog
// forces an ack to the owner if the slave stays silent for TIMEOUT cycles.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_wb_cpu_ibus_*              ibus master request (adr, cyc)
//   o_wb_cpu_ibus_rdt/ack        ibus response
//   i_wb_cpu_dbus_*              dbus master request (adr, dat, sel, we, cyc)
//   o_wb_cpu_dbus_rdt/ack        dbus response
//   o_wb_cpu_*                   shared request to the slave side
//   i_wb_cpu_rdt/ack             slave response
//   o_ibus_active                high while ibus holds the grant
//   o_timeout                    one-cycle pulse when the watchdog fires
module serv_wb_rr_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_cpu_ibus_adr,
    input  logic        i_wb_cpu_ibus_cyc,
    output logic [31:0] o_wb_cpu_ibus_rdt,
    output logic        o_wb_cpu_ibus_ack,
    input  logic [31:0] i_wb_cpu_dbus_adr,
    input  logic [31:0] i_wb_cpu_dbus_dat,
    input  logic [3:0]  i_wb_cpu_dbus_sel,
    input  logic        i_wb_cpu_dbus_we,
    input  logic        i_wb_cpu_dbus_cyc,
    output logic [31:0] o_wb_cpu_dbus_rdt,
    output logic        o_wb_cpu_dbus_ack,
    output logic [31:0] o_wb_cpu_adr,
    output logic [31:0] o_wb_cpu_dat,
    output logic [3:0]  o_wb_cpu_sel,
    output logic        o_wb_cpu_we,
    output logic        o_wb_cpu_cyc,
    input  logic [31:0] i_wb_cpu_rdt,
    input  logic        i_wb_cpu_ack,
    output logic        o_ibus_active,
    output logic        o_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       last_q;   // 0: ibus served last, 1: dbus served last
    logic       last_d;

    logic owner_cyc;
    logic owner_is_d;
    logic wdt_clr;
    logic wdt_en;
    logic wdt_expire;
    logic ack_fire;

    always_comb begin
        owner_cyc  = 1'b0;
        owner_is_d = 1'b0;
        case (state_q)
            GNT_I: owner_cyc = i_wb_cpu_ibus_cyc;
            GNT_D: begin
                owner_cyc  = i_wb_cpu_dbus_cyc;
                owner_is_d = 1'b1;
            end
            default: ;
        endcase
    end

    // The watchdog only runs while the owner is actually waiting; expiry is
    // therefore never raised on a cycle that carries a real ack.
    assign wdt_clr = (state_q == IDLE);
    assign wdt_en  = (state_q != IDLE) && owner_cyc && !i_wb_cpu_ack;

    serv_wb_wdt #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wdt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (wdt_clr),
        .i_en     (wdt_en),
        .o_expire (wdt_expire)
    );

    // owner_cyc is 0 in IDLE, so slave acks seen while idle go nowhere.
    assign ack_fire = owner_cyc && (i_wb_cpu_ack || wdt_expire);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_wb_cpu_ibus_cyc && (!i_wb_cpu_dbus_cyc || last_q)) begin
                    state_d = GNT_I;
                end else if (i_wb_cpu_dbus_cyc) begin
                    state_d = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (ack_fire) begin
                    state_d = IDLE;
                    last_d  = owner_is_d;
                end else if (!owner_cyc) begin
                    // Abort: the owner gave up, fairness history is kept.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign o_wb_cpu_cyc = owner_cyc;
    assign o_wb_cpu_adr = owner_is_d ? i_wb_cpu_dbus_adr : i_wb_cpu_ibus_adr;
    assign o_wb_cpu_dat = i_wb_cpu_dbus_dat;
    assign o_wb_cpu_sel = i_wb_cpu_dbus_sel;
    assign o_wb_cpu_we  = owner_is_d && i_wb_cpu_dbus_we;

    assign o_wb_cpu_ibus_rdt = i_wb_cpu_rdt;
    assign o_wb_cpu_dbus_rdt = i_wb_cpu_rdt;
    assign o_wb_cpu_ibus_ack = (state_q == GNT_I) && ack_fire;
    assign o_wb_cpu_dbus_ack = (state_q == GNT_D) && ack_fire;

    assign o_ibus_active = (state_q == GNT_I);
    assign o_timeout     = owner_cyc && wdt_expire;

endmodule

// File: tb/tb_serv_wb_rr_arbiter.sv
module tb_serv_wb_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we;
    logic        dbus_cyc;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_dat;
    logic [3:0]  cpu_sel;
    logic        cpu_we;
    logic        cpu_cyc;
    logic [31:0] cpu_rdt;
    logic        cpu_ack;
    logic        ibus_active;
    logic        timeout;

    logic        slave_ack;
    logic        spur_ack;
    int          slave_lat;

    int checks;
    int failures;

    logic [69:0] grant_q[$];   // {active, we, sel, adr, dat}
    logic [34:0] ack_q[$];     // {ibus_ack, dbus_ack, timeout, rdt}

    assign cpu_ack = slave_ack | spur_ack;

    serv_wb_rr_arbiter #(.TIMEOUT(4)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_wb_cpu_ibus_adr (ibus_adr),
        .i_wb_cpu_ibus_cyc (ibus_cyc),
        .o_wb_cpu_ibus_rdt (ibus_rdt),
        .o_wb_cpu_ibus_ack (ibus_ack),
        .i_wb_cpu_dbus_adr (dbus_adr),
        .i_wb_cpu_dbus_dat (dbus_dat),
        .i_wb_cpu_dbus_sel (dbus_sel),
        .i_wb_cpu_dbus_we  (dbus_we),
        .i_wb_cpu_dbus_cyc (dbus_cyc),
        .o_wb_cpu_dbus_rdt (dbus_rdt),
        .o_wb_cpu_dbus_ack (dbus_ack),
        .o_wb_cpu_adr      (cpu_adr),
        .o_wb_cpu_dat      (cpu_dat),
        .o_wb_cpu_sel      (cpu_sel),
        .o_wb_cpu_we       (cpu_we),
        .o_wb_cpu_cyc      (cpu_cyc),
        .i_wb_cpu_rdt      (cpu_rdt),
        .i_wb_cpu_ack      (cpu_ack),
        .o_ibus_active     (ibus_active),
        .o_timeout         (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic exp_grant(input logic act, input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] dat);
        grant_q.push_back({act, we, sel, adr, dat});
    endtask

    task automatic exp_ack(input logic is_i, input logic to, input logic [31:0] rdt);
        ack_q.push_back({is_i, ~is_i, to, rdt});
    endtask

    // Slave: acks slave_lat cycles into a transfer (slave_lat<=0: never acks).
    initial begin
        int  cnt;
        logic nxt;
        slave_ack = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            nxt = 1'b0;
            if (slave_ack) begin
                cnt = 0;
            end else if (cpu_cyc) begin
                cnt++;
                if (slave_lat > 0 && cnt == slave_lat) nxt = 1'b1;
            end else begin
                cnt = 0;
            end
            @(posedge clk);
            #1 slave_ack = nxt;
        end
    end

    // Monitor: compares every grant start and every master ack against the queues.
    initial begin
        logic prev_cyc;
        logic [69:0] e;
        logic [34:0] a;
        prev_cyc = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu_cyc && !prev_cyc) begin
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", {ibus_active, cpu_we, cpu_sel, cpu_adr, cpu_dat}, 70'h0);
                end else begin
                    e = grant_q.pop_front();
                    check("grant", {ibus_active, cpu_we, cpu_sel, cpu_adr, cpu_dat}, e);
                end
            end
            if (ibus_ack || dbus_ack) begin
                a = {ibus_ack, dbus_ack, timeout, ibus_ack ? ibus_rdt : dbus_rdt};
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", {35'h0, a}, 70'h0);
                end else begin
                    check("ack", {35'h0, a}, {35'h0, ack_q.pop_front()});
                end
            end else if (timeout) begin
                check("timeout_without_ack", {69'h0, timeout}, 70'h0);
            end
            prev_cyc = cpu_cyc;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        ibus_cyc = 1'b0;
        dbus_cyc = 1'b0;
        spur_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic ibus_txn(input logic [31:0] adr);
        int n;
        logic got;
        ibus_adr = adr;
        ibus_cyc = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = ibus_ack;
            n++;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ibus_wait actual=no_ack required=ack_within_100");
        end
        @(posedge clk);
        #1 ibus_cyc = 1'b0;
    endtask

    task automatic dbus_txn(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we);
        int n;
        logic got;
        dbus_adr = adr;
        dbus_dat = dat;
        dbus_sel = sel;
        dbus_we  = we;
        dbus_cyc = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = dbus_ack;
            n++;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL dbus_wait actual=no_ack required=ack_within_100");
        end
        @(posedge clk);
        #1 dbus_cyc = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ibus_adr = '0;
        dbus_adr = '0;
        dbus_dat = '0;
        dbus_sel = '0;
        dbus_we  = 1'b0;
        cpu_rdt  = '0;
        slave_lat = 2;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_cyc", {69'h0, cpu_cyc}, 70'h0);
        check("rst_acks", {68'h0, ibus_ack, dbus_ack}, 70'h0);
        check("rst_active", {69'h0, ibus_active}, 70'h0);
        check("rst_timeout", {69'h0, timeout}, 70'h0);

        // Single ibus read, one-cycle arbitration latency
        @(posedge clk); #1;
        cpu_rdt = 32'h1111_2222;
        exp_grant(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        exp_ack(1'b1, 1'b0, 32'h1111_2222);
        fork
            ibus_txn(32'h100);
            begin
                @(negedge clk);
                check("lat_idle_cyc", {69'h0, cpu_cyc}, 70'h0);
                @(negedge clk);
                check("lat_gnt_cyc", {69'h0, cpu_cyc}, 70'h1);
                check("lat_gnt_adr", {38'h0, cpu_adr}, 70'h100);
                check("lat_gnt_we", {69'h0, cpu_we}, 70'h0);
            end
        join

        // Simultaneous request after reset: ibus first, then dbus write
        do_reset();
        cpu_rdt = 32'h3333_4444;
        exp_grant(1'b1, 1'b0, 4'hF, 32'h104, 32'hDEAD_BEEF);
        exp_ack(1'b1, 1'b0, 32'h3333_4444);
        exp_grant(1'b0, 1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF);
        exp_ack(1'b0, 1'b0, 32'h3333_4444);
        fork
            ibus_txn(32'h104);
            dbus_txn(32'h200, 32'hDEAD_BEEF, 4'hF, 1'b1);
        join

        // Continuous contention: strict alternation I,D,I,D,I,D
        do_reset();
        cpu_rdt = 32'h5555_6666;
        for (int k = 0; k < 3; k++) begin
            exp_grant(1'b1, 1'b0, 4'h3, 32'h300 + 32'(4 * k), 32'h1234_5678);
            exp_ack(1'b1, 1'b0, 32'h5555_6666);
            exp_grant(1'b0, 1'b0, 4'h3, 32'h400 + 32'(4 * k), 32'h1234_5678);
            exp_ack(1'b0, 1'b0, 32'h5555_6666);
        end
        fork
            begin
                for (int k = 0; k < 3; k++) ibus_txn(32'h300 + 32'(4 * k));
            end
            begin
                for (int k = 0; k < 3; k++) dbus_txn(32'h400 + 32'(4 * k), 32'h1234_5678, 4'h3, 1'b0);
            end
        join

        // Watchdog on a silent slave, after an ibus transfer made ibus last
        do_reset();
        cpu_rdt = 32'h7777_8888;
        exp_grant(1'b1, 1'b0, 4'h3, 32'h500, 32'h1234_5678);
        exp_ack(1'b1, 1'b0, 32'h7777_8888);
        ibus_txn(32'h500);
        slave_lat = 0;
        cpu_rdt = 32'hBAD0_BAD0;
        exp_grant(1'b0, 1'b1, 4'h1, 32'h504, 32'hCAFE_0001);
        exp_ack(1'b0, 1'b1, 32'hBAD0_BAD0);
        fork
            dbus_txn(32'h504, 32'hCAFE_0001, 4'h1, 1'b1);
            begin
                int n;
                n = 0;
                while (!cpu_cyc && n < 20) begin @(negedge clk); n++; end
                n = 1;
                while (!dbus_ack && n < 20) begin @(negedge clk); n++; end
                check("wdt_gnt_cycles", 70'(n), 70'd4);
                check("wdt_timeout_pulse", {69'h0, timeout}, 70'h1);
                @(negedge clk);
                check("wdt_back_idle", {68'h0, cpu_cyc, ibus_active}, 70'h0);
                check("wdt_pulse_once", {69'h0, timeout}, 70'h0);
            end
        join
        slave_lat = 2;
        cpu_rdt = 32'h9999_AAAA;
        exp_grant(1'b1, 1'b0, 4'h2, 32'h508, 32'h0000_00AA);
        exp_ack(1'b1, 1'b0, 32'h9999_AAAA);
        exp_grant(1'b0, 1'b0, 4'h2, 32'h50C, 32'h0000_00AA);
        exp_ack(1'b0, 1'b0, 32'h9999_AAAA);
        fork
            ibus_txn(32'h508);
            dbus_txn(32'h50C, 32'h0000_00AA, 4'h2, 1'b0);
        join

        // Spurious ack in IDLE, then ibus abort leaves last untouched
        do_reset();
        slave_lat = 0;
        spur_ack = 1'b1;
        @(negedge clk);
        check("spur_acks", {68'h0, ibus_ack, dbus_ack}, 70'h0);
        @(posedge clk); #1 spur_ack = 1'b0;
        dbus_adr = 32'h600; dbus_dat = 32'h0; dbus_sel = 4'h0; dbus_we = 1'b0;
        exp_grant(1'b1, 1'b0, 4'h0, 32'h610, 32'h0);
        ibus_adr = 32'h610;
        ibus_cyc = 1'b1;
        repeat (2) @(posedge clk);
        #1 ibus_cyc = 1'b0;
        @(negedge clk);
        check("abort_cyc_drop", {68'h0, cpu_cyc, ibus_ack}, 70'h0);
        @(negedge clk);
        check("abort_idle", {69'h0, ibus_active}, 70'h0);
        slave_lat = 2;
        cpu_rdt = 32'hBBBB_CCCC;
        exp_grant(1'b1, 1'b0, 4'h4, 32'h620, 32'h0000_0055);
        exp_ack(1'b1, 1'b0, 32'hBBBB_CCCC);
        exp_grant(1'b0, 1'b0, 4'h4, 32'h624, 32'h0000_0055);
        exp_ack(1'b0, 1'b0, 32'hBBBB_CCCC);
        @(posedge clk); #1;
        fork
            ibus_txn(32'h620);
            dbus_txn(32'h624, 32'h0000_0055, 4'h4, 1'b0);
        join

        // Reset during an ibus grant, before any ack
        slave_lat = 0;
        exp_grant(1'b1, 1'b0, 4'h4, 32'h700, 32'h0000_0055);
        ibus_adr = 32'h700;
        ibus_cyc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_granted", {69'h0, ibus_active}, 70'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        ibus_cyc = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_state", {67'h0, cpu_cyc, ibus_active, ibus_ack}, 70'h0);
        slave_lat = 2;
        cpu_rdt = 32'hDDDD_EEEE;
        exp_grant(1'b1, 1'b0, 4'h8, 32'h710, 32'h0000_0077);
        exp_ack(1'b1, 1'b0, 32'hDDDD_EEEE);
        exp_grant(1'b0, 1'b1, 4'h8, 32'h714, 32'h0000_0077);
        exp_ack(1'b0, 1'b0, 32'hDDDD_EEEE);
        @(posedge clk); #1;
        fork
            ibus_txn(32'h710);
            dbus_txn(32'h714, 32'h0000_0077, 4'h8, 1'b1);
        join

        repeat (4) @(posedge clk);
        check("grant_queue_drained", 70'(grant_q.size()), 70'd0);
        check("ack_queue_drained", 70'(ack_q.size()), 70'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/serv_wb_rr_arbiter.md
Name: serv_wb_rr_arbiter

Overview:
- Registered two-master Wishbone arbiter. Shares the single CPU Wishbone port between the SERV instruction bus (ibus) and data bus (dbus).
- Replaces the externally supplied ibus-active select with an internal grant FSM:
  - round-robin between masters;
  - grant held for the full cycle;
  - watchdog forces completion when the slave never acks.
- Sits between the serv_top ibus/dbus ports and the memory/peripheral interconnect in bench and SoC tops.

Parameters:
- TIMEOUT, 255, cycles a granted transfer may wait for i_wb_cpu_ack before forced termination; 0 disables the watchdog.
- TW, $clog2(TIMEOUT+1), watchdog counter width (derived, not overridden).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_wb_cpu_ibus_adr  in  32  ibus address
- i_wb_cpu_ibus_cyc  in  1  ibus request
- o_wb_cpu_ibus_rdt  out  32  ibus read data
- o_wb_cpu_ibus_ack  out  1  ibus ack
- i_wb_cpu_dbus_adr  in  32  dbus address
- i_wb_cpu_dbus_dat  in  32  dbus write data
- i_wb_cpu_dbus_sel  in  4  dbus byte select
- i_wb_cpu_dbus_we  in  1  dbus write enable
- i_wb_cpu_dbus_cyc  in  1  dbus request
- o_wb_cpu_dbus_rdt  out  32  dbus read data
- o_wb_cpu_dbus_ack  out  1  dbus ack
- o_wb_cpu_adr  out  32  shared address
- o_wb_cpu_dat  out  32  shared write data
- o_wb_cpu_sel  out  4  shared byte select
- o_wb_cpu_we  out  1  shared write enable
- o_wb_cpu_cyc  out  1  shared cycle
- i_wb_cpu_rdt  in  32  slave read data
- i_wb_cpu_ack  in  1  slave ack
- o_ibus_active  out  1  1 while state is GNT_I
- o_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Clocking and reset:
  - Single clock i_clk.
  - Reset is synchronous, active-high i_rst, applied on the rising edge.
- State register: states IDLE, GNT_I, GNT_D. Also holds register last (0 = ibus served last, 1 = dbus served last) and watchdog counter wdt.
- Reset values: state=IDLE, last=1 (ibus wins the first tie), wdt=0.
  - All outputs resolve from these values: o_wb_cpu_cyc=0, both acks=0, o_ibus_active=0, o_timeout=0.
- IDLE transitions:
  - ibus_cyc only -> GNT_I.
  - dbus_cyc only -> GNT_D.
  - Both -> the master not equal to last.
  - Neither -> stay.
  - Arbitration latency is 1 cycle: request seen in cycle N, o_wb_cpu_cyc high in N+1.
- GNT_x behaviour:
  - o_wb_cpu_cyc = owner's cyc.
  - o_wb_cpu_adr = owner's adr.
  - dat/sel always come from dbus.
  - o_wb_cpu_we = dbus_we when GNT_D, else 0.
- GNT_x exit:
  - On i_wb_cpu_ack & owner cyc: route ack to the owner only, set last=owner, go to IDLE next cycle.
  - This gives one mandatory idle cycle between transfers.
- Abort: owner cyc deasserted without ack -> IDLE. last is unchanged.
- Ack/rdt routing:
  - Both rdt outputs = i_wb_cpu_rdt, unmasked.
  - Acks are gated by the granted state. A slave ack in IDLE is dropped, and no master sees it.
- Watchdog (TIMEOUT>0):
  - wdt clears on entry to GNT_x and increments each GNT cycle without ack.
  - When wdt==TIMEOUT-1 and no ack arrives:
    - assert the owner's ack for one cycle, with rdt passed through (undefined data);
    - pulse o_timeout;
    - set last=owner and go to IDLE.
  - A real ack on the expiry cycle takes precedence; o_timeout stays 0.
- Non-owner behaviour: cyc changes from the non-owner during GNT are ignored until IDLE.
- Reset mid-transfer: state returns to IDLE on the next edge and the pending ack is discarded. The master is reset alongside.

Decomposition:
- No shared package needed. The state encoding is a local 2-bit enum: IDLE=0, GNT_I=1, GNT_D=2.
- One natural sub-module, serv_wb_wdt: a TIMEOUT-parameterised counter with clr/en inputs and an expire output. The rest is a single flat module.

Test Plan:
- Reset release, ibus_cyc=1 adr=0x100, slave acks 2 cycles after cyc -> o_wb_cpu_cyc rises 1 cycle after request; adr=0x100; we=0; ibus_ack pulses once with rdt; dbus_ack stays 0.
- ibus_cyc and dbus_cyc raised in the same cycle after reset -> ibus granted first. After its ack, one IDLE cycle, then dbus granted with we/sel/dat=0xDEADBEEF presented.
- Both masters requesting continuously for 6 transfers -> grants strictly alternate I,D,I,D,I,D.
- GNT_D, slave never acks, TIMEOUT=4 -> dbus_ack and o_timeout pulse on the 4th GNT cycle, state returns to IDLE, next tie goes to ibus.
- Spurious i_wb_cpu_ack while IDLE, and owner drops cyc mid-GNT -> no ack reaches either master; the abort returns to IDLE with last unchanged.
- i_rst asserted during GNT_I before ack -> next cycle o_wb_cpu_cyc=0, no ack, state IDLE, first tie again goes to ibus.
